mem_access_stage: RTL

- MEM stage of the Minisys-1A pipeline. It consumes the EX/MEM register outputs and runs a load/store/IO access on the shared data bus, using a req/ack handshake with wait states and a timeout.
- It steers sub-word data, extends load data, and holds the pipeline with stall while an access is outstanding.
- It registers the write-back fields (the MEM/WB boundary) for the WB stage.

---
 rtl/minisys_mem_pkg.sv | 17 +
 rtl/mem_lane_align.sv | 41 ++++
 rtl/mem_access_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/minisys_mem_pkg.sv
// Shared encodings for the Minisys-1A MEM stage: FSM state codes and
// access-width codes from the EX/MEM register.
package minisys_mem_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  // Both 10 and 11 select a full-word access.
  function automatic logic is_word(input logic [1:0] width);
    return width[1];
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction and extension for loads,
// plus the alignment check for the current access.
module mem_lane_align
  import minisys_mem_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  addr_lo,
  input  logic        sign,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    shifted   = rdata >> {addr_lo, 3'b000};
    lane_b    = shifted[7:0];
    lane_h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    byte_en   = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    if (width == W_BYTE) begin
      byte_en   = 4'b0001 << addr_lo;
      wdata     = {4{store_data[7:0]}};
      load_data = sign ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
    end else if (width == W_HALF) begin
      byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
      wdata     = {2{store_data[15:0]}};
      load_data = sign ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
    end
    misaligned = ((width == W_HALF) && addr_lo[0]) ||
                 (is_word(width) && (addr_lo != 2'b00));
  end

endmodule

// File: rtl/mem_access_stage.sv
// Minisys-1A MEM stage: req/ack bus access with timeout, pipeline stall,
// and the MEM/WB write-back register boundary.
module mem_access_stage
  import minisys_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Memory_read_in,
  input  logic        Memory_write_in,
  input  logic        IO_read_in,
  input  logic        IO_write_in,
  input  logic        Memory_sign_in,
  input  logic [1:0]  Memory_data_width_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] Memory_or_IO_write_data_in,
  input  logic        Register_write_in,
  input  logic [4:0]  Write_back_address_in,
  input  logic [31:0] PC_exception_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_io,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byte_en,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall,
  output logic        Register_write_out,
  output logic [4:0]  Write_back_address_out,
  output logic [31:0] Write_back_data_out,
  output logic        Misaligned_out,
  output logic        Bus_error_out,
  output logic [31:0] Bad_address_out,
  output logic [31:0] PC_exception_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             access, is_write, misaligned, timeout;
  logic [3:0]       byte_en;
  logic [31:0]      wdata, load_data;

  assign access   = Memory_read_in | Memory_write_in | IO_read_in | IO_write_in;
  assign is_write = Memory_write_in | IO_write_in;

  mem_lane_align u_align (
    .width      (Memory_data_width_in),
    .addr_lo    (ALU_result_in[1:0]),
    .sign       (Memory_sign_in),
    .store_data (Memory_or_IO_write_data_in),
    .rdata      (bus_rdata),
    .byte_en    (byte_en),
    .wdata      (wdata),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  always_comb begin
    timeout = (state == WAIT) && !bus_ack && (cnt == CNT_LAST);
    if (state == IDLE) stall = access && !misaligned;
    else               stall = !(bus_ack || timeout);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_io      <= 1'b0;
      bus_addr    <= '0;
      bus_byte_en <= '0;
      bus_wdata   <= '0;
    end else if (state == IDLE) begin
      if (access && !misaligned) begin
        state       <= WAIT;
        cnt         <= '0;
        bus_req     <= 1'b1;
        bus_we      <= is_write;
        bus_io      <= IO_read_in | IO_write_in;
        bus_addr    <= {ALU_result_in[31:2], 2'b00};
        bus_byte_en <= byte_en;
        bus_wdata   <= wdata;
      end
    end else begin
      if (bus_ack || timeout) begin
        state   <= IDLE;
        bus_req <= 1'b0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // While stalled the EX/MEM inputs are held, so they still describe the
  // access that is completing when stall finally drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      Register_write_out     <= 1'b0;
      Write_back_address_out <= '0;
      Write_back_data_out    <= '0;
      Misaligned_out         <= 1'b0;
      Bus_error_out          <= 1'b0;
      Bad_address_out        <= '0;
      PC_exception_out       <= '0;
    end else if (!stall) begin
      PC_exception_out       <= PC_exception_in;
      Write_back_address_out <= Write_back_address_in;
      Write_back_data_out    <= ALU_result_in;
      Register_write_out     <= Register_write_in;
      Misaligned_out         <= 1'b0;
      Bus_error_out          <= 1'b0;
      Bad_address_out        <= '0;
      if (state == IDLE && access && misaligned) begin
        Misaligned_out     <= 1'b1;
        Register_write_out <= 1'b0;
        Bad_address_out    <= ALU_result_in;
      end else if (timeout) begin
        Bus_error_out      <= 1'b1;
        Register_write_out <= 1'b0;
        Bad_address_out    <= ALU_result_in;
      end else if (state == WAIT && !is_write) begin
        Write_back_data_out <= load_data;
      end
    end
  end

endmodule
